// File: rtl/fft_pkg.sv
// Shared types for the FFT datapath.
//   DATA_WIDTH     : width of one real or imaginary component
//   complex_t      : one complex sample, also the frame-buffer RAM word
//   feeder_state_t : read-side states of fft_frame_feeder
package fft_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    FF_IDLE,
    FF_BURST,
    FF_GAP
  } feeder_state_t;

endpackage

// File: rtl/fft_frame_feeder_ram.sv
// Simple dual-port frame buffer RAM: one write port, one read port.
// The read data is registered, so it appears one cycle after the read.
// The array has no reset.
//   clk     : clock
//   we_i    : write enable; waddr_i and wdata_i are the write address and data
//   re_i    : read enable; raddr_i is the read address
//   rdata_o : read data, valid the cycle after re_i
module frame_ram #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Packs a bursty complex sample stream into FFT_SIZE-sample frames in a
// ping-pong buffer. Each complete frame is replayed as an unbroken burst, so
// fft_sc sees din_valid high for exactly FFT_SIZE cycles.
//   clk, rst_n      : clock; synchronous active-low reset
//   s_re/s_im       : input sample; s_valid/s_ready form the handshake
//   flush           : discard the partially filled frame
//   m_re/m_im       : output sample to fft_sc
//   m_valid         : output valid to fft_sc
//   frame_start     : high with the first sample of each burst
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int unsigned FFT_SIZE = 16,
  parameter int unsigned MIN_GAP  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_re,
  input  logic [DATA_WIDTH-1:0] s_im,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_re,
  output logic [DATA_WIDTH-1:0] m_im,
  output logic                  m_valid,
  output logic                  frame_start
);

  localparam int unsigned PTR_W  = $clog2(FFT_SIZE);
  localparam int unsigned ADDR_W = PTR_W + 1;
  localparam int unsigned GAP_W  = 8;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FFT_SIZE - 1);

  // Write side
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       full_q, full_d;
  logic             wr_en_c, fill_c;
  complex_t         wr_word_c;

  // Read side
  feeder_state_t    state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rd_bank_q, rd_bank_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rd_en_c, rd_first_c, release_c, next_full_c, other_bank_c;
  logic             rd_vld_q, rd_first_q;
  complex_t         rd_word;

  // Output registers
  logic                  m_valid_q, frame_start_q;
  logic [DATA_WIDTH-1:0] m_re_q, m_im_q;

  assign s_ready   = rst_n & ~full_q[wr_bank_q];
  // flush takes priority: a sample offered alongside it is dropped.
  assign wr_en_c   = s_valid & s_ready & ~flush;
  assign fill_c    = wr_en_c & (wr_ptr_q == LAST_PTR);
  assign wr_word_c = '{re: s_re, im: s_im};

  // Write pointer / bank next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    if (flush) begin
      wr_ptr_d = '0;
    end else if (wr_en_c) begin
      wr_ptr_d = fill_c ? '0 : PTR_W'(wr_ptr_q + 1'b1);
      if (fill_c) wr_bank_d = ~wr_bank_q;
    end
  end

  // Fill and release always touch different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (release_c) full_d[rd_bank_q] = 1'b0;
    if (fill_c)    full_d[wr_bank_q] = 1'b1;
  end

  // With no forced gap, a bank completing on this same edge still continues
  // the burst seamlessly.
  assign other_bank_c = ~rd_bank_q;
  assign next_full_c  = full_q[other_bank_c] | (fill_c & (wr_bank_q == other_bank_c));

  // Read FSM next state and read-port controls.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    gap_d     = gap_q;
    rd_en_c   = 1'b0;
    release_c = 1'b0;
    case (state_q)
      FF_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_en_c  = 1'b1;
          rd_ptr_d = PTR_W'(1);
          state_d  = FF_BURST;
        end
      end
      FF_BURST: begin
        rd_en_c  = 1'b1;
        rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        if (rd_ptr_q == LAST_PTR) begin
          release_c = 1'b1;
          rd_ptr_d  = '0;
          rd_bank_d = ~rd_bank_q;
          if (MIN_GAP > 0) begin
            state_d = FF_GAP;
            gap_d   = GAP_W'(MIN_GAP - 1);
          end else if (next_full_c) begin
            state_d = FF_BURST;
          end else begin
            state_d = FF_IDLE;
          end
        end
      end
      FF_GAP: begin
        if (gap_q == '0) state_d = FF_IDLE;
        else             gap_d   = GAP_W'(gap_q - 1'b1);
      end
      default: state_d = FF_IDLE;
    endcase
  end

  assign rd_first_c = rd_en_c & (rd_ptr_q == '0);

  frame_ram #(
    .DEPTH (2 * FFT_SIZE),
    .WIDTH ($bits(complex_t))
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en_c),
    .waddr_i ({wr_bank_q, wr_ptr_q}),
    .wdata_i (wr_word_c),
    .re_i    (rd_en_c),
    .raddr_i ({rd_bank_q, rd_ptr_q}),
    .rdata_o (rd_word)
  );

  // State and pipeline registers; rd_vld_q tracks the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      full_q        <= '0;
      state_q       <= FF_IDLE;
      rd_ptr_q      <= '0;
      rd_bank_q     <= 1'b0;
      gap_q         <= '0;
      rd_vld_q      <= 1'b0;
      rd_first_q    <= 1'b0;
      m_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      m_re_q        <= '0;
      m_im_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      full_q        <= full_d;
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_bank_q     <= rd_bank_d;
      gap_q         <= gap_d;
      rd_vld_q      <= rd_en_c;
      rd_first_q    <= rd_first_c;
      m_valid_q     <= rd_vld_q;
      frame_start_q <= rd_first_q;
      m_re_q        <= rd_vld_q ? rd_word.re : '0;
      m_im_q        <= rd_vld_q ? rd_word.im : '0;
    end
  end

  assign m_valid     = m_valid_q;
  assign frame_start = frame_start_q;
  assign m_re        = m_re_q;
  assign m_im        = m_im_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: one instance with MIN_GAP=1 and one with
// MIN_GAP=0, both FFT_SIZE=16, checked against a sample scoreboard.
module tb_fft_frame_feeder;
  import fft_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = DATA_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] s_re, s_im, m_re, m_im;
  logic          s_valid, s_ready, flush, m_valid, frame_start;
  logic [DW-1:0] b_s_re, b_s_im, b_m_re, b_m_im;
  logic          b_s_valid, b_s_ready, b_flush, b_m_valid, b_frame_start;

  fft_frame_feeder #(.FFT_SIZE(N), .MIN_GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_re(s_re), .s_im(s_im), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .m_re(m_re), .m_im(m_im),
    .m_valid(m_valid), .frame_start(frame_start)
  );

  fft_frame_feeder #(.FFT_SIZE(N), .MIN_GAP(0)) u_dut_nogap (
    .clk(clk), .rst_n(rst_n), .s_re(b_s_re), .s_im(b_s_im), .s_valid(b_s_valid),
    .s_ready(b_s_ready), .flush(b_flush), .m_re(b_m_re), .m_im(b_m_im),
    .m_valid(b_m_valid), .frame_start(b_frame_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboards: samples enter pend_q on transfer and move to exp_q as whole frames.
  complex_t pend_q[$];
  complex_t exp_q[$];
  complex_t exp0_q[$];
  int rises_q[$];
  int gaps_q[$];
  int runs0_q[$];
  int cyc = 0, run = 0, idle = 0, run0 = 0, fs0_cnt = 0, stalls = 0, last_edge = 0;

  // Monitor for the MIN_GAP=1 instance, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    complex_t e;
    #1;
    cyc++;
    if (!rst_n) begin
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_frame_start", 32'(frame_start), 0);
      chk("rst_m_re", 32'(m_re), 0);
      chk("rst_m_im", 32'(m_im), 0);
      run  = 0;
      idle = 0;
    end else if (m_valid) begin
      if (run == 0) begin
        rises_q.push_back(cyc);
        gaps_q.push_back(idle);
      end
      idle = 0;
      chk("burst_not_overlong", 32'(run < N), 1);
      chk("frame_start", 32'(frame_start), 32'(run == 0));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_output: got re=%0d with empty scoreboard, required no m_valid", m_re);
      end else begin
        e = exp_q.pop_front();
        chk("m_re", 32'(m_re), 32'(e.re));
        chk("m_im", 32'(m_im), 32'(e.im));
      end
      run++;
    end else begin
      if (run != 0) chk("burst_len", 32'(run), N);
      run = 0;
      idle++;
    end
  end

  // Monitor for the MIN_GAP=0 instance.
  always @(posedge clk) begin
    complex_t e;
    #1;
    if (!rst_n) begin
      run0 = 0;
    end else if (b_m_valid) begin
      chk("nogap_frame_start", 32'(b_frame_start), 32'((run0 % N) == 0));
      if (b_frame_start) fs0_cnt++;
      if (exp0_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL nogap_spurious_output: got re=%0d, required no m_valid", b_m_re);
      end else begin
        e = exp0_q.pop_front();
        chk("nogap_m_re", 32'(b_m_re), 32'(e.re));
        chk("nogap_m_im", 32'(b_m_im), 32'(e.im));
      end
      run0++;
    end else begin
      if (run0 != 0) runs0_q.push_back(run0);
      run0 = 0;
    end
  end

  // Offer n samples (re=base+k, im=-(base+k)) with the given valid duty in percent.
  task automatic send(input int n, input int base, input int duty);
    int k = 0;
    int budget = 0;
    while (k < n && budget < 20000) begin
      @(negedge clk);
      budget++;
      s_valid = ($urandom_range(99) < 32'(duty));
      s_re    = DW'(base + k);
      s_im    = DW'(-(base + k));
      if (s_valid && !s_ready) stalls++;
      if (s_valid && s_ready && rst_n && !flush) begin
        pend_q.push_back('{re: s_re, im: s_im});
        k++;
        last_edge = cyc + 1;
        if (pend_q.size() == N) begin
          foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
          pend_q.delete();
        end
      end
    end
    if (k < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got %0d transfers, required %0d", k, n);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_nogap(input int n);
    int k = 0;
    int budget = 0;
    while (k < n && budget < 2000) begin
      @(negedge clk);
      budget++;
      b_s_valid = 1'b1;
      b_s_re    = DW'(k);
      b_s_im    = DW'(-k);
      if (b_s_ready && rst_n) begin
        exp0_q.push_back('{re: b_s_re, im: b_s_im});
        k++;
      end
    end
    if (k < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL nogap_send_timeout: got %0d transfers, required %0d", k, n);
    end
    @(negedge clk);
    b_s_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    s_valid = 1'b0;
    flush   = 1'b1;
    pend_q.delete();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || m_valid || exp0_q.size() != 0 || b_m_valid) && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d samples outstanding, required 0", exp_q.size() + exp0_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_run(input int target);
    int b = 0;
    while (run < target && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (run < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_output_timeout: got run %0d, required %0d", run, target);
    end
  endtask

  typedef struct {
    int n;
    int base;
    int duty;
    bit flush_after;
    int exp_bursts;
    int exp_gap;      // -1: gaps not checked
    bit exp_stall;
    bit chk_lat;
  } row_t;

  row_t rows[5];

  initial begin
    rows[0] = '{n: 16,  base: 0,   duty: 100, flush_after: 0, exp_bursts: 1,  exp_gap: -1, exp_stall: 0, chk_lat: 1};
    rows[1] = '{n: 64,  base: 0,   duty: 100, flush_after: 0, exp_bursts: 4,  exp_gap: 1,  exp_stall: 1, chk_lat: 0};
    rows[2] = '{n: 5,   base: 200, duty: 100, flush_after: 1, exp_bursts: 0,  exp_gap: -1, exp_stall: 0, chk_lat: 0};
    rows[3] = '{n: 16,  base: 100, duty: 100, flush_after: 0, exp_bursts: 1,  exp_gap: -1, exp_stall: 0, chk_lat: 0};
    rows[4] = '{n: 160, base: 300, duty: 40,  flush_after: 0, exp_bursts: 10, exp_gap: -1, exp_stall: 0, chk_lat: 0};

    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_re = 16'h1234; s_im = 16'h5678;
    b_s_valid = 1'b1; b_s_re = '0; b_s_im = '0; b_flush = 1'b0;

    // Reset held with s_valid high: nothing may be accepted.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_nogap_s_ready", 32'(b_s_ready), 0);
    end
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0; b_s_valid = 1'b0;
    #1;
    chk("s_ready_after_rst", 32'(s_ready), 1);

    for (int r = 0; r < 5; r++) begin
      rises_q.delete();
      gaps_q.delete();
      stalls = 0;
      send(rows[r].n, rows[r].base, rows[r].duty);
      if (rows[r].flush_after) do_flush();
      drain();
      chk($sformatf("row%0d_bursts", r), 32'(rises_q.size()), 32'(rows[r].exp_bursts));
      if (rows[r].exp_gap >= 0)
        for (int i = 1; i < rises_q.size(); i++)
          chk($sformatf("row%0d_gap%0d", r, i), 32'(gaps_q[i]), 32'(rows[r].exp_gap));
      if (rows[r].exp_stall) chk($sformatf("row%0d_s_ready_fell", r), 32'(stalls > 0), 1);
      if (rows[r].chk_lat && rises_q.size() > 0)
        chk($sformatf("row%0d_latency", r), 32'(rises_q[0]), 32'(last_edge + 2));
    end

    // Flush during an active burst: that burst completes untouched.
    rises_q.delete();
    send(16, 500, 100);
    wait_run(1);
    send(3, 600, 100);
    do_flush();
    chk("flush_mid_burst_m_valid", 32'(m_valid), 1);
    send(16, 700, 100);
    drain();
    chk("flush_mid_burst_bursts", 32'(rises_q.size()), 2);

    // Reset at the 8th output sample truncates the burst; next frame is clean.
    rises_q.delete();
    send(16, 800, 100);
    wait_run(8);
    rst_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_burst_m_valid", 32'(m_valid), 0);
    rises_q.delete();
    send(16, 900, 100);
    drain();
    chk("post_rst_bursts", 32'(rises_q.size()), 1);

    // MIN_GAP=0 instance: three frames back to back form one 48-cycle burst.
    runs0_q.delete();
    fs0_cnt = 0;
    send_nogap(48);
    drain();
    chk("nogap_runs", 32'(runs0_q.size()), 1);
    if (runs0_q.size() > 0) chk("nogap_run_len", 32'(runs0_q[0]), 48);
    chk("nogap_frame_starts", 32'(fs0_cnt), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
